// File: rtl/lce_pkg.sv
// lce_pkg: definitions shared by the local-contrast-enhancement blocks.
//   - Default frame geometry (IMG_W, IMG_H), pixel-index width (IDX_W).
//   - WIN_SIZE: side length of the square window, also used by img_window
//     and the contrast unit.
//   - lce_state_e: 3-bit state encoding of the scan controller.
package lce_pkg;

  localparam int IMG_W    = 128;
  localparam int IMG_H    = 128;
  localparam int IDX_W    = 15;
  localparam int WIN_SIZE = 45;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_WIN  = 3'd1,
    ST_CALC      = 3'd2,
    ST_WAIT_CALC = 3'd3,
    ST_WRITE     = 3'd4,
    ST_NEXT      = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERR       = 3'd7
  } lce_state_e;

endpackage

// File: rtl/lce_wait_timer.sv
// lce_wait_timer: loadable wait-state timeout counter.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : forces the count to zero (held while not waiting)
//   en        : counts one per cycle while high
//   limit     : number of waiting cycles allowed
//   expired   : high during the limit-th cycle of a wait (count == limit-1)
module lce_wait_timer #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);
  import lce_pkg::*;

  logic [TO_W-1:0] cnt;

  // The count equals the number of cycles already spent waiting, so the
  // limit-th waiting cycle sees cnt == limit-1 and the caller leaves on
  // that edge. The count freezes once expired.
  assign expired = en && (cnt == limit - TO_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/lce_scan_ctrl.sv
// lce_scan_ctrl: frame scheduler for the local-contrast-enhancement path.
// Walks the output image in raster order; for every pixel it requests a
// window from img_window, starts the contrast unit, then strobes one
// write-back. Each wait state is supervised by a timeout.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : frame request pulse (needs padding_completed)
//   padding_completed   : padding engine finished
//   abort               : synchronous return to IDLE
//   win_req / win_idx   : window request level and pixel index
//   window_fetched      : window ready (used only in WAIT_WIN)
//   calc_start          : one-cycle start pulse to the contrast unit
//   calc_done           : contrast result ready (used only in WAIT_CALC)
//   wb_en / wb_addr     : one-cycle write strobe and output address
//   busy, done          : activity and frame-complete status
//   err_timeout         : sticky timeout flag
//   pix_count           : pixels written this frame
module lce_scan_ctrl #(
  parameter int IMG_W       = lce_pkg::IMG_W,
  parameter int IMG_H       = lce_pkg::IMG_H,
  parameter int IDX_W       = lce_pkg::IDX_W,
  parameter int TIMEOUT_CYC = 65535,
  parameter int TO_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             padding_completed,
  input  logic             abort,
  output logic             win_req,
  output logic [IDX_W-1:0] win_idx,
  input  logic             window_fetched,
  output logic             calc_start,
  input  logic             calc_done,
  output logic             wb_en,
  output logic [IDX_W-1:0] wb_addr,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [IDX_W-1:0] pix_count
);
  import lce_pkg::*;

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_W * IMG_H - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC);

  lce_state_e       state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] pix_cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             done_q, err_q;
  logic             in_wait, expired;
  logic             accept, advance, set_done, set_err;

  assign in_wait = (state == ST_WAIT_WIN) || (state == ST_WAIT_CALC);

  // The timer is held clear outside the two wait states, so it always
  // starts from zero on entry to either of them.
  lce_wait_timer #(.TO_W(TO_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_wait),
    .en      (in_wait),
    .limit   (TO_LIMIT),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Abort overrides everything; within a wait state completion beats
  // timeout.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    set_done  = 1'b0;
    set_err   = 1'b0;
    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start && padding_completed) begin
            state_nxt = ST_WAIT_WIN;
            accept    = 1'b1;
          end
        end
        ST_WAIT_WIN: begin
          if (window_fetched) begin
            state_nxt = ST_CALC;
          end else if (expired) begin
            state_nxt = ST_ERR;
            set_err   = 1'b1;
          end
        end
        ST_CALC:      state_nxt = ST_WAIT_CALC;
        ST_WAIT_CALC: begin
          if (calc_done) begin
            state_nxt = ST_WRITE;
          end else if (expired) begin
            state_nxt = ST_ERR;
            set_err   = 1'b1;
          end
        end
        ST_WRITE:     state_nxt = ST_NEXT;
        ST_NEXT: begin
          if (idx == LAST_IDX) begin
            state_nxt = ST_DONE;
            set_done  = 1'b1;
          end else begin
            state_nxt = ST_WAIT_WIN;
            advance   = 1'b1;
          end
        end
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      col     <= '0;
      row     <= '0;
      pix_cnt <= '0;
    end else if (accept) begin
      idx     <= '0;
      col     <= '0;
      row     <= '0;
      pix_cnt <= '0;
    end else begin
      if (state == ST_WRITE) pix_cnt <= pix_cnt + IDX_W'(1);
      if (advance) begin
        idx <= idx + IDX_W'(1);
        if (col == LAST_COL) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // done and err_timeout are registered so that abort leaves them intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (set_done) done_q <= 1'b1;
      if (set_err)  err_q  <= 1'b1;
    end
  end

  assign win_req     = (state == ST_WAIT_WIN);
  assign win_idx     = idx;
  assign calc_start  = (state == ST_CALC);
  assign wb_en       = (state == ST_WRITE);
  assign wb_addr     = idx;
  assign busy        = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERR);
  assign done        = done_q;
  assign err_timeout = err_q;
  assign pix_count   = pix_cnt;

endmodule

// File: tb/tb_lce_scan_ctrl.sv
// tb_lce_scan_ctrl: directed bench for lce_scan_ctrl on a 4x3 frame with
// a 20-cycle timeout. A cycle table covers start gating, stray completions
// and abort; hand-written sequences cover a full frame, timeout, abort in
// WAIT_CALC, the completion/timeout race and asynchronous reset.
module tb_lce_scan_ctrl;
  localparam int IMG_W       = 4;
  localparam int IMG_H       = 3;
  localparam int IDX_W       = 15;
  localparam int TIMEOUT_CYC = 20;
  localparam int TO_W        = 16;
  localparam int FETCH_DLY   = 3;
  localparam int CALC_DLY    = 2;
  localparam int OBS_W       = 6 + 3 * IDX_W;

  logic             clk = 1'b0;
  logic             rst, start, padding_completed, abort;
  logic             window_fetched, calc_done;
  logic             win_req, calc_start, wb_en, busy, done, err_timeout;
  logic [IDX_W-1:0] win_idx, wb_addr, pix_count;

  lce_scan_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .IDX_W(IDX_W),
    .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .padding_completed(padding_completed),
    .abort(abort), .win_req(win_req), .win_idx(win_idx),
    .window_fetched(window_fetched), .calc_start(calc_start),
    .calc_done(calc_done), .wb_en(wb_en), .wb_addr(wb_addr), .busy(busy),
    .done(done), .err_timeout(err_timeout), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  bit resp_en   = 1'b0;
  int hang_win  = -1;
  int hang_calc = -1;
  int fw_cnt    = 0;
  int cd_cnt    = 0;

  typedef struct {
    logic             st, pad, ab, wf, cd;
    logic [OBS_W-1:0] exp;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [OBS_W-1:0] obs();
    return {win_req, calc_start, wb_en, busy, done, err_timeout,
            win_idx, wb_addr, pix_count};
  endfunction

  function automatic logic [OBS_W-1:0] ex(bit wr, bit cs, bit we, bit bz,
                                          bit dn, bit er, int ix, int pc);
    return {wr, cs, we, bz, dn, er, IDX_W'(ix), IDX_W'(ix), IDX_W'(pc)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural img_window / contrast unit: fetch completes on the third
  // cycle of a request, calc completes two cycles after calc_start.
  always begin
    @(posedge clk);
    #1;
    if (resp_en) begin
      window_fetched = 1'b0;
      calc_done      = 1'b0;
      if (win_req && (int'(win_idx) != hang_win)) begin
        fw_cnt++;
        if (fw_cnt == FETCH_DLY) begin
          window_fetched = 1'b1;
          fw_cnt         = 0;
        end
      end else begin
        fw_cnt = 0;
      end
      if (calc_start) begin
        cd_cnt = (int'(win_idx) == hang_calc) ? 0 : CALC_DLY;
      end else if (cd_cnt > 0) begin
        cd_cnt--;
        if (cd_cnt == 0) calc_done = 1'b1;
      end
    end
  end

  initial begin
    int n;
    int seen;
    rst = 1'b1; start = 1'b0; padding_completed = 1'b0; abort = 1'b0;
    window_fetched = 1'b0; calc_done = 1'b0;
    #2;
    chk("reset_outputs", 64'(obs()), 64'(0));
    step();
    rst = 1'b0;

    //            st    pad   ab    wf    cd    wr cs we bz dn er idx pc
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ex(1, 0, 0, 1, 0, 0, 0, 0)};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ex(1, 0, 0, 1, 0, 0, 0, 0)};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ex(1, 0, 0, 1, 0, 0, 0, 0)};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ex(1, 0, 0, 1, 0, 0, 0, 0)};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ex(0, 1, 0, 1, 0, 0, 0, 0)};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ex(0, 0, 0, 1, 0, 0, 0, 0)};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ex(0, 0, 0, 1, 0, 0, 0, 0)};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ex(0, 0, 1, 1, 0, 0, 0, 0)};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 1, 0, 0, 0, 1)};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ex(1, 0, 0, 1, 0, 0, 1, 1)};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 1, 1)};

    for (int i = 0; i < 13; i++) begin
      start = tbl[i].st; padding_completed = tbl[i].pad; abort = tbl[i].ab;
      window_fetched = tbl[i].wf; calc_done = tbl[i].cd;
      step();
      chk($sformatf("vec%0d", i), 64'(obs()), 64'(tbl[i].exp));
    end
    start = 1'b0; abort = 1'b0; window_fetched = 1'b0; calc_done = 1'b0;
    padding_completed = 1'b1;

    // Full 4x3 frame.
    resp_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 1000; c++) begin
      if (wb_en) begin
        chk($sformatf("wb_addr%0d", n), 64'(wb_addr), 64'(n));
        n++;
      end
      if (done) break;
      step();
    end
    chk("frame_wb_count", 64'(n), 64'(12));
    chk("frame_status", 64'({done, busy, err_timeout}), 64'(3'b100));
    chk("frame_pix_count", 64'(pix_count), 64'(12));

    // Window never arrives for pixel 5.
    hang_win = 5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (win_req && (win_idx == IDX_W'(5))) break;
      step();
    end
    chk("to_reach_idx5", 64'(win_req && (win_idx == IDX_W'(5))), 64'(1));
    repeat (TIMEOUT_CYC - 1) step();
    chk("to_pending", 64'({busy, err_timeout, win_req}), 64'(3'b101));
    step();
    chk("to_err", 64'({busy, err_timeout, win_req, win_idx}),
        64'({1'b0, 1'b1, 1'b0, IDX_W'(5)}));
    step();
    chk("to_err_hold", 64'({busy, err_timeout, win_idx}), 64'({1'b0, 1'b1, IDX_W'(5)}));
    hang_win = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("to_restart", 64'({err_timeout, win_req, win_idx}), 64'({1'b0, 1'b1, IDX_W'(0)}));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("to_abort_idle", 64'({busy, win_req}), 64'(2'b00));

    // Abort while waiting on the contrast unit at pixel 7.
    hang_calc = 7;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (calc_start && (win_idx == IDX_W'(7))) break;
      step();
    end
    step();
    chk("ab_wait_calc", 64'({busy, calc_start, wb_en, win_req, win_idx}),
        64'({4'b1000, IDX_W'(7)}));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_idle", 64'({busy, win_req, calc_start, wb_en, done, err_timeout}), 64'(0));
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (wb_en || busy) seen++;
      step();
    end
    chk("ab_no_wb", 64'(seen), 64'(0));
    hang_calc = -1;
    resp_en = 1'b0;
    window_fetched = 1'b0;
    calc_done = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ab_restart", 64'({win_req, win_idx, pix_count}), 64'({1'b1, IDX_W'(0), IDX_W'(0)}));

    // calc_done arrives in the very cycle the timer expires.
    window_fetched = 1'b1;
    step();
    window_fetched = 1'b0;
    chk("race_calc", 64'({calc_start, win_req}), 64'(2'b10));
    step();
    for (int c = 0; c < TIMEOUT_CYC - 1; c++) begin
      window_fetched = (c == 3);
      step();
    end
    window_fetched = 1'b0;
    chk("race_pending", 64'({busy, err_timeout, wb_en, calc_start}), 64'(4'b1000));
    calc_done = 1'b1;
    step();
    calc_done = 1'b0;
    chk("race_write", 64'({wb_en, err_timeout, busy, wb_addr}), 64'({3'b101, IDX_W'(0)}));
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Asynchronous reset in the middle of pixel 3.
    resp_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (win_req && (win_idx == IDX_W'(3))) break;
      step();
    end
    chk("rst_reach_idx3", 64'(win_idx), 64'(3));
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async", 64'(obs()), 64'(0));
    #3;
    rst = 1'b0;
    resp_en = 1'b0;
    window_fetched = 1'b0;
    calc_done = 1'b0;
    step();
    chk("rst_idle", 64'(obs()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
